// File: rtl/reg_file.sv
// 32 x 32-bit MIPS general-purpose register file: two combinational read ports,
// one clocked write port, and a registered copy of the last committed write data.
module reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] addr_1_i,
    input  logic [ADDR_WIDTH-1:0] addr_2_i,
    input  logic [ADDR_WIDTH-1:0] addr_3_i,
    input  logic [DATA_WIDTH-1:0] write_data_3_i,
    input  logic                  write_enable_i,
    output logic [DATA_WIDTH-1:0] read_data_1_o,
    output logic [DATA_WIDTH-1:0] read_data_2_o,
    output logic [DATA_WIDTH-1:0] a
);

    localparam int NumRegs = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] a_q;
    logic                  write_hit;

    // Writes to register 0 are dropped entirely, including the debug copy.
    assign write_hit = write_enable_i && (addr_3_i != '0);

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            a_q <= '0;
        end else if (write_hit) begin
            regs_q[addr_3_i] <= write_data_3_i;
            a_q              <= write_data_3_i;
        end
    end

    // No write-to-read bypass: reads see the array as it stands before the edge.
    always_comb begin
        read_data_1_o = '0;
        read_data_2_o = '0;
        if (addr_1_i != '0) begin
            read_data_1_o = regs_q[addr_1_i];
        end
        if (addr_2_i != '0) begin
            read_data_2_o = regs_q[addr_2_i];
        end
    end

    assign a = a_q;

endmodule

// File: tb/tb_reg_file.sv
// Randomised and directed bench for reg_file; expected read/debug values come from
// an array model and are checked by a separate negedge monitor through a queue.
module tb_reg_file;

    logic        clk;
    logic        reset_i;
    logic [4:0]  addr_1_i;
    logic [4:0]  addr_2_i;
    logic [4:0]  addr_3_i;
    logic [31:0] write_data_3_i;
    logic        write_enable_i;
    logic [31:0] read_data_1_o;
    logic [31:0] read_data_2_o;
    logic [31:0] a;

    reg_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .addr_1_i      (addr_1_i),
        .addr_2_i      (addr_2_i),
        .addr_3_i      (addr_3_i),
        .write_data_3_i(write_data_3_i),
        .write_enable_i(write_enable_i),
        .read_data_1_o (read_data_1_o),
        .read_data_2_o (read_data_2_o),
        .a             (a)
    );

    typedef struct {
        string       tag;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ea;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_regs [32];
    logic [31:0] model_a;
    int          n_cmp = 0;
    int          n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'd0 : model_regs[addr];
    endfunction

    // Drive one cycle's inputs, queue the expected pre-edge view, then commit the
    // edge into the model.
    task automatic step(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] w, input logic [31:0] wd, input logic we,
                        input string tag, input bit chk);
        exp_t e;
        reset_i        = rst;
        addr_1_i       = r1;
        addr_2_i       = r2;
        addr_3_i       = w;
        write_data_3_i = wd;
        write_enable_i = we;
        if (chk) begin
            e.tag = tag;
            e.e1  = model_read(r1);
            e.e2  = model_read(r2);
            e.ea  = model_a;
            sb.push_back(e);
        end
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            model_a = 32'd0;
        end else if (we && w != 5'd0) begin
            model_regs[w] = wd;
            model_a       = wd;
        end
        #1;
    endtask

    task automatic check(input string tag, input string field, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h, expected %h", tag, field, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.tag, "rd1", read_data_1_o, e.e1);
                check(e.tag, "rd2", read_data_2_o, e.e2);
                check(e.tag, "a", a, e.ea);
            end
        end
    end

    initial begin
        int waited;
        model_a = 32'hx;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'hx;

        step(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, "reset", 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, "rst_a0", 1'b1);
        step(1'b1, 5'd1, 5'd1, 5'd0, 32'd0, 1'b0, "rst_a1", 1'b1);
        step(1'b1, 5'd31, 5'd31, 5'd0, 32'd0, 1'b0, "rst_a31", 1'b1);

        step(1'b1, 5'd0, 5'd0, 5'd1, 32'd1, 1'b1, "wr1", 1'b1);
        step(1'b1, 5'd0, 5'd0, 5'd2, 32'd2, 1'b1, "wr2", 1'b1);
        step(1'b1, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, "rd12", 1'b1);

        for (int i = 0; i < 3; i++) step(1'b1, 5'd4, 5'd1, 5'd4, 32'd32, 1'b0, "we_off", 1'b1);
        step(1'b1, 5'd4, 5'd2, 5'd0, 32'd0, 1'b0, "we_off_rd", 1'b1);

        step(1'b1, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 1'b1, "wr_zero", 1'b1);
        step(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, "rd_zero", 1'b1);

        step(1'b1, 5'd5, 5'd5, 5'd5, 32'd7, 1'b1, "set5", 1'b1);
        step(1'b1, 5'd5, 5'd5, 5'd5, 32'd9, 1'b1, "pre_edge", 1'b1);
        step(1'b1, 5'd5, 5'd5, 5'd0, 32'd0, 1'b0, "post_edge", 1'b1);

        step(1'b1, 5'd3, 5'd3, 5'd3, 32'd1, 1'b1, "set3", 1'b1);
        step(1'b0, 5'd3, 5'd3, 5'd3, 32'h55, 1'b1, "rst_wr", 1'b1);
        step(1'b1, 5'd3, 5'd5, 5'd0, 32'd0, 1'b0, "after_rst", 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), 5'($urandom), 5'($urandom),
                 5'($urandom), $urandom, 1'($urandom_range(0, 1)), "rand", 1'b1);
        end
        step(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, "final", 1'b1);

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
